// File: rtl/elixirchip_es1_spu_reg_arbiter.sv
// ============================================================================
// Module  : elixirchip_es1_spu_reg_arbiter
// Brief   : Round-robin write arbiter sharing one op_reg between N requesters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module elixirchip_es1_spu_reg_arbiter #(
    parameter int    N            = 4,
    parameter int    DATA_BITS    = 8,
    parameter int    DONE_LATENCY = 3,
    parameter string DEVICE       = "RTL",
    parameter string SIMULATION   = "false",
    parameter string DEBUG        = "false"
) (
    input  logic                   reset,
    input  logic                   clk,
    input  logic                   cke,
    input  logic [N-1:0]           s_req,
    input  logic [N-1:0]           s_clear,
    input  logic [N*DATA_BITS-1:0] s_data,
    output logic [N-1:0]           s_ready,
    output logic [DATA_BITS-1:0]   m_data,
    output logic                   m_clear,
    output logic                   m_valid,
    output logic [N-1:0]           m_done
);

    localparam int c_IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [c_IDX_W-1:0] r_ptr;
    logic [c_IDX_W-1:0] r_m_idx;
    logic [c_IDX_W-1:0] w_gnt_idx;
    logic [c_IDX_W-1:0] w_ptr_nxt;
    logic [c_IDX_W:0]   w_scan;
    logic               w_found;
    logic               w_xfer;
    logic               w_last_v;
    logic [c_IDX_W-1:0] w_last_i;

    // Scan upward from the pointer with wrap; first asserted request wins.
    always_comb begin
        s_ready   = '0;
        w_gnt_idx = '0;
        w_found   = 1'b0;
        w_scan    = '0;
        for (int k = 0; k < N; k++) begin
            w_scan = {1'b0, r_ptr} + (c_IDX_W+1)'(k);
            if (w_scan >= (c_IDX_W+1)'(N)) begin
                w_scan = w_scan - (c_IDX_W+1)'(N);
            end
            if (!w_found && s_req[w_scan[c_IDX_W-1:0]]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_scan[c_IDX_W-1:0];
            end
        end
        w_xfer = w_found && cke && !reset;
        if (w_xfer) begin
            s_ready[w_gnt_idx] = 1'b1;
        end
    end

    assign w_ptr_nxt = (w_gnt_idx == c_IDX_W'(N-1)) ? '0 : w_gnt_idx + c_IDX_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr   <= '0;
            r_m_idx <= '0;
            m_data  <= '0;
            m_clear <= 1'b0;
            m_valid <= 1'b0;
        end else if (cke) begin
            m_valid <= w_xfer;
            m_clear <= w_xfer && s_clear[w_gnt_idx];
            if (w_xfer) begin
                r_ptr   <= w_ptr_nxt;
                r_m_idx <= w_gnt_idx;
                m_data  <= s_data[int'(w_gnt_idx)*DATA_BITS +: DATA_BITS];
            end
        end
    end

    // Completion pipeline mirrors the op_reg latency so m_done lines up with m_data.
    generate
        if (DONE_LATENCY > 0) begin : g_pipe
            logic [DONE_LATENCY-1:0]              r_dv;
            logic [DONE_LATENCY-1:0][c_IDX_W-1:0] r_di;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_dv <= '0;
                    r_di <= '0;
                end else if (cke) begin
                    r_dv <= (r_dv << 1) | DONE_LATENCY'(m_valid);
                    r_di <= (r_di << c_IDX_W) | (DONE_LATENCY*c_IDX_W)'(r_m_idx);
                end
            end

            assign w_last_v = r_dv[DONE_LATENCY-1];
            assign w_last_i = r_di[DONE_LATENCY-1];
        end else begin : g_nopipe
            assign w_last_v = m_valid;
            assign w_last_i = r_m_idx;
        end
    endgenerate

    always_comb begin
        m_done = '0;
        if (w_last_v && cke && !reset) begin
            m_done[w_last_i] = 1'b1;
        end
    end

    generate
        if (SIMULATION == "true") begin : g_sim
            always_ff @(posedge clk) begin
                if (!reset) begin
                    assert ($onehot0(s_ready)) else $error("%s: s_ready not one-hot", DEVICE);
                    assert ((s_ready & ~s_req) == '0) else $error("%s: grant without request", DEVICE);
                    assert ($onehot0(m_done)) else $error("%s: m_done not one-hot", DEVICE);
                end
            end
        end
        if (DEBUG == "true") begin : g_debug
            (* mark_debug = "true" *) logic [c_IDX_W-1:0] r_dbg_ptr;
            always_ff @(posedge clk) begin
                r_dbg_ptr <= r_ptr;
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_elixirchip_es1_spu_reg_arbiter.sv
// ============================================================================
// Module  : tb_elixirchip_es1_spu_reg_arbiter
// Brief   : Directed scoreboard bench for the round-robin op_reg write arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_elixirchip_es1_spu_reg_arbiter;

    localparam int N  = 4;
    localparam int DB = 8;
    localparam int DL = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              cke;
    logic [N-1:0]      s_req;
    logic [N-1:0]      s_clear;
    logic [N*DB-1:0]   s_data;
    logic [N-1:0]      s_ready;
    logic [DB-1:0]     m_data;
    logic              m_clear;
    logic              m_valid;
    logic [N-1:0]      m_done;

    always #5 clk = ~clk;

    elixirchip_es1_spu_reg_arbiter #(
        .N            (N),
        .DATA_BITS    (DB),
        .DONE_LATENCY (DL),
        .DEVICE       ("RTL"),
        .SIMULATION   ("true"),
        .DEBUG        ("false")
    ) dut (
        .reset   (reset),
        .clk     (clk),
        .cke     (cke),
        .s_req   (s_req),
        .s_clear (s_clear),
        .s_data  (s_data),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_clear (m_clear),
        .m_valid (m_valid),
        .m_done  (m_done)
    );

    typedef struct packed {
        logic [DB-1:0] data;
        logic          clr;
        logic [1:0]    idx;
    } wr_t;

    typedef struct {
        int idx;
        int due;
    } dn_t;

    wr_t           wr_q[$];
    dn_t           dn_q[$];
    int            ptr       = 0;
    logic          exp_mv    = 1'b0;
    logic [DB-1:0] last_data = '0;
    int            kc        = 0;
    int            total     = 0;
    int            bad       = 0;

    function automatic logic [N-1:0] model_grant();
        logic [N-1:0] g;
        g = '0;
        if (reset || !cke) return g;
        for (int k = 0; k < N; k++) begin
            if (s_req[(ptr + k) % N]) begin
                g[(ptr + k) % N] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // One clock: compare at negedge, then advance the reference model over the edge.
    task automatic cyc();
        logic [N-1:0] er;
        logic [N-1:0] ed;
        wr_t          w;
        int           gi;
        @(negedge clk);
        er = model_grant();
        chk("s_ready", 32'(s_ready), 32'(er));
        chk("m_valid", 32'(m_valid), 32'(exp_mv));
        if (exp_mv && wr_q.size() > 0) begin
            chk("m_data", 32'(m_data), 32'(wr_q[0].data));
            chk("m_clear", 32'(m_clear), 32'(wr_q[0].clr));
        end else begin
            chk("m_data_hold", 32'(m_data), 32'(last_data));
            chk("m_clear_idle", 32'(m_clear), 32'd0);
        end
        ed = '0;
        if (!reset && cke && dn_q.size() > 0 && dn_q[0].due == kc) ed[dn_q[0].idx] = 1'b1;
        chk("m_done", 32'(m_done), 32'(ed));

        if (reset) begin
            wr_q.delete();
            dn_q.delete();
            exp_mv    = 1'b0;
            ptr       = 0;
            last_data = '0;
        end else if (cke) begin
            if (ed != '0) void'(dn_q.pop_front());
            if (exp_mv && wr_q.size() > 0) begin
                w = wr_q.pop_front();
                dn_q.push_back('{int'(w.idx), kc + DL});
                last_data = w.data;
            end
            if (er != '0) begin
                gi = 0;
                for (int i = 0; i < N; i++) if (er[i]) gi = i;
                wr_q.push_back('{s_data[gi*DB +: DB], s_clear[gi], 2'(gi)});
                ptr    = (gi + 1) % N;
                exp_mv = 1'b1;
            end else begin
                exp_mv = 1'b0;
            end
            kc++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        cke     = 1'b1;
        s_req   = 4'hF;
        s_clear = '0;
        s_data  = '0;
        cyc();
        cyc();

        // single requester from idle
        reset = 1'b0;
        s_req = 4'b0100;
        s_data[2*DB +: DB] = 8'h55;
        #1 chk("single_grant", 32'(s_ready), 32'h4);
        cyc();
        s_req = '0;
        repeat (6) cyc();

        // four-way stream from reset with a two-cycle cke stall
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        s_req  = 4'hF;
        s_data = {8'h13, 8'h12, 8'h11, 8'h10};
        #1 chk("stream_first", 32'(s_ready), 32'h1);
        repeat (6) cyc();
        cke = 1'b0;
        repeat (2) cyc();
        cke = 1'b1;
        repeat (6) cyc();
        s_req = '0;
        repeat (6) cyc();

        // pointer wrap after granting requester 3
        s_req = 4'b1000;
        cyc();
        s_req = 4'b1010;
        #1 chk("wrap_first", 32'(s_ready), 32'h2);
        cyc();
        #1 chk("wrap_second", 32'(s_ready), 32'h8);
        cyc();
        s_req = '0;
        repeat (5) cyc();

        // clear write from requester 1
        s_req   = 4'b0010;
        s_clear = 4'b0010;
        s_data[1*DB +: DB] = 8'd99;
        cyc();
        s_req   = '0;
        s_clear = '0;
        repeat (5) cyc();

        // reset one cycle after a transfer discards its completion
        s_req = 4'hF;
        cyc();
        s_req = '0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        s_req = 4'hF;
        #1 chk("post_reset_grant", 32'(s_ready), 32'h1);
        cyc();
        s_req = '0;
        repeat (6) cyc();

        chk("drain_done", 32'(dn_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
